ysyx_ifu: RTL and testbench
===========================

Name: ysyx_ifu

Overview:
Instruction fetch stage directly upstream of the decode stage. Holds the architectural PC and issues word fetches to instruction memory over a req/resp handshake. Presents {inst, pc} to decode over a valid/ready handshake and accepts PC redirects from the jump path (jal/jalr targets). Supports a halt request, driven on ebreak, that stops further fetching.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, value driven on inst when out_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  fetch address; equals pc.
imem_resp_valid  in  1  response data valid; memory never stalls responses.
imem_resp_data  in  32  fetched instruction word.
out_valid  out  1  inst/pc valid toward decode.
out_ready  in  1  decode consumes inst/pc this cycle.
inst  out  32  instruction to decode.
pc  out  32  address of inst.
redirect_valid  in  1  take redirect_pc as next fetch PC.
redirect_pc  in  32  jump target.
halt  in  1  stop issuing new fetches; level-sensitive.
misaligned  out  1  sticky; set when a redirect target has [1:0]!=0.

Behaviour:
- States: REQ, WAIT, HOLD, DROP, STOP. Reset state is REQ.
- Reset values: pc_r=RESET_PC, inst_r=NOP_INST, imem_req_valid=0 for the reset cycle and then asserted in REQ, out_valid=0, misaligned=0.
- REQ: imem_req_valid=1, addr=pc_r. On req_ready, go to WAIT. If halt=1 on entry to REQ, go to STOP instead and drop req_valid.
- WAIT: on resp_valid, inst_r<=resp_data and go to HOLD. A response in the same cycle as acceptance is illegal (response latency ≥1 cycle).
- HOLD: out_valid=1, inst=inst_r, pc=pc_r. On out_ready: pc_r<=pc_r+4 (mod 2^32, wraps at 32'hFFFF_FFFC), then go to REQ.
- Redirect has priority over every other event in the same cycle, out handshake included. pc_r<=redirect_pc.
  - From REQ or HOLD: go to REQ. The request is not accepted that cycle; imem_req_valid stays high but the address updates next cycle.
  - From WAIT with no resp_valid this cycle: go to DROP, where the next resp_valid is discarded, then REQ.
  - From WAIT with resp_valid this cycle: discard the data and go to REQ.
  - From STOP: pc_r updates and the state stays STOP.
- A redirect with redirect_pc[1:0]!=0 sets misaligned=1 (cleared only by rst), loads pc_r, and forces STOP.
- STOP: no requests and out_valid=0. Leave STOP for REQ when halt=0 and misaligned=0.
- halt asserted in WAIT or HOLD lets the current instruction complete normally, then STOP replaces REQ.
- inst=NOP_INST whenever out_valid=0. pc always reflects pc_r.
- Reset mid-transaction: the outstanding memory response is ignored. The memory model is reset together with the block.
- One fetch outstanding max. Throughput is at most one instruction per 3 cycles (REQ, WAIT, HOLD).

Test Plan:
- Reset then req_ready=1 and resp 1 cycle later with data 32'h00100093, out_ready=1 -> addr=80000000, inst=00100093 and pc=80000000 in HOLD, next request addr=80000004.
- out_ready held 0 for 5 cycles in HOLD -> out_valid, inst and pc stable and no new request; release -> pc advances by 4 exactly once.
- redirect_valid with redirect_pc=80000100 while in WAIT, resp arriving 2 cycles later with 32'hDEADBEEF -> DEADBEEF never appears on inst; next request addr=80000100.
- Simultaneous out_ready and redirect in HOLD (pc=80000008, target=80000020) -> next fetch addr=80000020, not 8000000C.
- redirect_pc=80000102 -> misaligned=1, req_valid=0 permanently until rst; assert rst mid-WAIT -> pc=80000000, misaligned=0.
- halt=1 during WAIT -> current inst delivered, then STOP with no req; halt=0 -> fetch resumes at pc+4.

Source files
------------

// File: rtl/ysyx_ifu.sv
// Instruction fetch stage: owns the architectural PC, fetches one word at a time from imem,
// and hands {inst, pc} to decode. Redirects override everything; halt parks the stage in STOP.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        misaligned
);
    typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, STOP} state_t;

    state_t      state, state_n, to_req;
    logic [31:0] pc_r, pc_n, inst_r, inst_n;
    logic        mis_r, mis_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= REQ;
            pc_r   <= RESET_PC;
            inst_r <= NOP_INST;
            mis_r  <= 1'b0;
        end else begin
            state  <= state_n;
            pc_r   <= pc_n;
            inst_r <= inst_n;
            mis_r  <= mis_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_r;
        inst_n  = inst_r;
        mis_n   = mis_r;
        // Any entry into REQ diverts to STOP while halt is held
        to_req  = halt ? STOP : REQ;
        unique case (state)
            REQ:  if (halt) state_n = STOP;
                  else if (imem_req_ready) state_n = WAIT;
            WAIT: if (imem_resp_valid) begin
                      inst_n  = imem_resp_data;
                      state_n = HOLD;
                  end
            HOLD: if (out_ready) begin
                      pc_n    = pc_r + 32'd4;
                      state_n = to_req;
                  end
            DROP: if (imem_resp_valid) state_n = to_req;
            STOP: if (!halt && !mis_r) state_n = REQ;
            default: state_n = REQ;
        endcase
        if (redirect_valid) begin
            pc_n   = redirect_pc;
            inst_n = inst_r;
            unique case (state)
                REQ, HOLD: state_n = to_req;
                WAIT:      state_n = imem_resp_valid ? to_req : DROP;
                DROP:      state_n = imem_resp_valid ? to_req : DROP;
                default:   state_n = STOP;
            endcase
            // A misaligned target is fatal until reset; any in-flight response is ignored in STOP
            if (redirect_pc[1:0] != 2'b00) begin
                mis_n   = 1'b1;
                state_n = STOP;
            end
        end
    end

    assign imem_req_valid = (state == REQ) && !halt && !rst;
    assign imem_req_addr  = pc_r;
    assign out_valid      = (state == HOLD);
    assign inst           = (state == HOLD) ? inst_r : NOP_INST;
    assign pc             = pc_r;
    assign misaligned     = mis_r;
endmodule

// File: tb/tb_ysyx_ifu.sv
// Bench for ysyx_ifu: directed vector table, hand-built corner sequences, then random traffic
// checked against an architectural PC/instruction model and a latency-randomised memory.
module tb_ysyx_ifu;
    localparam logic [31:0] R0  = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, rdy, rv, ordy, redv, hlt;
    logic [31:0] rd, rpc;
    logic        imem_req_valid, out_valid, misaligned;
    logic [31:0] imem_req_addr, inst, pc;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ysyx_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(rdy), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(rv), .imem_resp_data(rd),
        .out_valid(out_valid), .out_ready(ordy), .inst(inst), .pc(pc),
        .redirect_valid(redv), .redirect_pc(rpc), .halt(hlt), .misaligned(misaligned)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rd;
        logic        ordy, redv;
        logic [31:0] rpc;
        logic        hlt;
        logic        erq, eov;
        logic [31:0] einst, epc;
        logic        emis;
    } vec_t;

    function automatic vec_t V(input logic r, input logic a, input logic b, input logic [31:0] d,
                               input logic o, input logic rv_, input logic [31:0] t, input logic h,
                               input logic erq, input logic eov, input logic [31:0] ei,
                               input logic [31:0] ep, input logic em);
        vec_t v;
        v.rst = r; v.rdy = a; v.rv = b; v.rd = d; v.ordy = o; v.redv = rv_; v.rpc = t; v.hlt = h;
        v.erq = erq; v.eov = eov; v.einst = ei; v.epc = ep; v.emis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; rdy = v.rdy; rv = v.rv; rd = v.rd;
        ordy = v.ordy; redv = v.redv; rpc = v.rpc; hlt = v.hlt;
        #1;
        chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(v.erq));
        chk({tag, ".req_addr"},  imem_req_addr, v.epc);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.eov));
        chk({tag, ".inst"},      inst, v.einst);
        chk({tag, ".pc"},        pc, v.epc);
        chk({tag, ".misaligned"}, 32'(misaligned), 32'(v.emis));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    vec_t tbl[$];

    // random-phase model state
    logic [31:0] m_pc, paddr, tmp;
    logic        m_mis, pend, hs;
    int          wcnt, mis_age, ndeliv;

    initial begin
        rst = 1'b1; rdy = 0; rv = 0; rd = 0; ordy = 0; redv = 0; rpc = 0; hlt = 0;
        //            rst rdy rv data          ordy redv rpc          h   erq ov inst          pc           mis
        tbl.push_back(V(1, 0, 0, 0,            0,  0, 0,            0,  0, 0, NOP,          R0,            0));
        tbl.push_back(V(0, 1, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          R0,            0));
        tbl.push_back(V(0, 0, 1, 32'h00100093, 0,  0, 0,            0,  0, 0, NOP,          R0,            0));
        tbl.push_back(V(0, 0, 0, 0,            1,  0, 0,            0,  0, 1, 32'h00100093, R0,            0));
        tbl.push_back(V(0, 0, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000004,  0));
        tbl.push_back(V(0, 1, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000004,  0));
        tbl.push_back(V(0, 0, 1, 32'h00200113, 0,  0, 0,            0,  0, 0, NOP,          32'h80000004,  0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(V(0, 1, 0, 0,        0,  0, 0,            0,  0, 1, 32'h00200113, 32'h80000004,  0));
        tbl.push_back(V(0, 0, 0, 0,            1,  0, 0,            0,  0, 1, 32'h00200113, 32'h80000004,  0));
        tbl.push_back(V(0, 0, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000008,  0));
        tbl.push_back(V(0, 1, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000008,  0));
        tbl.push_back(V(0, 0, 1, 32'h00300193, 0,  0, 0,            0,  0, 0, NOP,          32'h80000008,  0));
        tbl.push_back(V(0, 0, 0, 0,            1,  1, 32'h80000020, 0,  0, 1, 32'h00300193, 32'h80000008,  0));
        tbl.push_back(V(0, 0, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000020,  0));
        tbl.push_back(V(0, 1, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000020,  0));
        tbl.push_back(V(0, 0, 0, 0,            0,  1, 32'h80000100, 0,  0, 0, NOP,          32'h80000020,  0));
        tbl.push_back(V(0, 0, 0, 0,            0,  0, 0,            0,  0, 0, NOP,          32'h80000100,  0));
        tbl.push_back(V(0, 0, 1, 32'hDEADBEEF, 1,  0, 0,            0,  0, 0, NOP,          32'h80000100,  0));
        tbl.push_back(V(0, 1, 0, 0,            0,  1, 32'h80000200, 0,  1, 0, NOP,          32'h80000100,  0));
        tbl.push_back(V(0, 0, 0, 0,            0,  0, 0,            0,  1, 0, NOP,          32'h80000200,  0));
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // halt during WAIT: current instruction delivered, then STOP, resume at pc+4
        apply(V(0, 1, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          32'h80000200, 0), "halt0");
        apply(V(0, 0, 0, 0,            0, 0, 0, 1, 0, 0, NOP,          32'h80000200, 0), "halt1");
        apply(V(0, 0, 1, 32'h00500293, 0, 0, 0, 1, 0, 0, NOP,          32'h80000200, 0), "halt2");
        apply(V(0, 0, 0, 0,            1, 0, 0, 1, 0, 1, 32'h00500293, 32'h80000200, 0), "halt3");
        for (int i = 0; i < 3; i++)
            apply(V(0, 1, 0, 0,        0, 0, 0, 1, 0, 0, NOP,          32'h80000204, 0), $sformatf("halt_stop%0d", i));
        apply(V(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, NOP,          32'h80000204, 0), "halt_rel");
        apply(V(0, 0, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          32'h80000204, 0), "halt_resume");

        // PC wrap at the top of the address space
        apply(V(0, 0, 0, 0,            0, 1, 32'hFFFFFFFC, 0, 1, 0, NOP, 32'h80000204, 0), "wrap0");
        apply(V(0, 1, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          32'hFFFFFFFC, 0), "wrap1");
        apply(V(0, 0, 1, 32'h00700393, 0, 0, 0, 0, 0, 0, NOP,          32'hFFFFFFFC, 0), "wrap2");
        apply(V(0, 0, 0, 0,            1, 0, 0, 0, 0, 1, 32'h00700393, 32'hFFFFFFFC, 0), "wrap3");
        apply(V(0, 0, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          32'h00000000, 0), "wrap4");

        // misaligned redirect is sticky until reset; reset mid-WAIT restarts cleanly
        apply(V(0, 0, 0, 0,            0, 1, 32'h80000102, 0, 1, 0, NOP, 32'h00000000, 0), "mis0");
        for (int i = 0; i < 3; i++)
            apply(V(0, 1, 0, 0,        0, 0, 0, 0, 0, 0, NOP,          32'h80000102, 1), $sformatf("mis_stop%0d", i));
        apply(V(0, 1, 0, 0,            0, 1, 32'h80000300, 0, 0, 0, NOP, 32'h80000102, 1), "mis_redir");
        apply(V(0, 1, 0, 0,            0, 0, 0, 0, 0, 0, NOP,          32'h80000300, 1), "mis_hold");
        apply(V(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, NOP,          R0,           0), "mis_rst");
        apply(V(0, 1, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          R0,           0), "rw0");
        apply(V(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, NOP,          R0,           0), "rw1");
        apply(V(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, NOP,          R0,           0), "rw_rst");
        apply(V(0, 1, 0, 0,            0, 0, 0, 0, 1, 0, NOP,          R0,           0), "rw2");
        apply(V(0, 0, 1, 32'h00600313, 0, 0, 0, 0, 0, 0, NOP,          R0,           0), "rw3");
        apply(V(0, 0, 0, 0,            1, 0, 0, 0, 0, 1, 32'h00600313, R0,           0), "rw4");

        // random traffic against the architectural model
        m_pc = R0; m_mis = 0; pend = 0; wcnt = 0; paddr = 0; mis_age = 0; ndeliv = 0;
        hlt = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 299) == 0) || (mis_age > 30);
            if (hlt) hlt = ($urandom_range(0, 9) != 0);
            else     hlt = ($urandom_range(0, 39) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            redv = !rst && ($urandom_range(0, 11) == 0);
            tmp  = $urandom;
            case ($urandom_range(0, 29))
                0:       rpc = {16'h8000, tmp[15:2], 2'(tmp[17:16] | 2'b01)};
                1:       rpc = 32'hFFFF_FFF8;
                default: rpc = {16'h8000, tmp[15:2], 2'b00};
            endcase
            rv = !rst && pend && (wcnt == 0);
            rd = rv ? memw(paddr) : $urandom;
            #1;
            if (rst) begin
                chk("rnd_rst.pc", pc, R0);
                chk("rnd_rst.mis", 32'(misaligned), 32'd0);
                chk("rnd_rst.req", 32'(imem_req_valid), 32'd0);
                chk("rnd_rst.ov", 32'(out_valid), 32'd0);
            end else begin
                chk("rnd.pc", pc, m_pc);
                chk("rnd.mis", 32'(misaligned), 32'(m_mis));
                if (imem_req_valid) chk("rnd.addr", imem_req_addr, m_pc);
                if (!out_valid) chk("rnd.nop", inst, NOP);
                if (hlt || pend || m_mis) chk("rnd.no_req", 32'(imem_req_valid), 32'd0);
                if (m_mis) chk("rnd.mis_noout", 32'(out_valid), 32'd0);
            end
            hs = !rst && out_valid && ordy && !redv;
            if (hs) begin
                chk("rnd.inst", inst, memw(m_pc));
                ndeliv++;
            end
            // advance the model across the coming edge
            if (rst) begin
                m_pc = R0; m_mis = 0; pend = 0; mis_age = 0;
            end else begin
                if (pend && !rv) wcnt--;
                if (rv) pend = 0;
                if (imem_req_valid && rdy && !redv) begin
                    pend = 1; paddr = m_pc; wcnt = $urandom_range(0, 2);
                end
                if (redv) begin
                    m_pc = rpc;
                    if (rpc[1:0] != 2'b00) m_mis = 1;
                end else if (hs) begin
                    m_pc = m_pc + 32'd4;
                end
                if (m_mis) mis_age++;
            end
            @(posedge clk);
            #1;
        end
        chk("rnd.progress", 32'(ndeliv >= 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
